// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver: serial double-dabble BCD plus anode scan.
// Define SSD_LZB_EN to blank most-significant zero digits.
module ssd_scan_driver #(
  parameter int DIGITS   = 2,
  parameter int BIN_W    = 7,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [BIN_W-1:0]  value,
  output logic              busy,
  output logic [6:0]        SSD,
  output logic [DIGITS-1:0] AN
);

  localparam int BCD_W = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t              state, state_nx;
  logic [BIN_W-1:0]    bin;
  logic [BCD_W-1:0]    bcd, bcd_adj;
  logic [CNT_W-1:0]    cnt;
  logic                carry;
  logic [4*DIGITS-1:0] disp;
  logic                disp_ovf;
  logic [DIV_W-1:0]    div;
  logic [1:0]          idx;
  logic [3:0]          cur_nib;
  logic                cur_blank;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = CONV;
      CONV:    if (cnt == CNT_W'(1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // carry catches digits shifted out of the top nibble
  always_ff @(posedge clk) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin   <= value;
            bcd   <= '0;
            cnt   <= CNT_W'(BIN_W);
            carry <= 1'b0;
          end
        end
        CONV: begin
          {bcd, bin} <= {bcd_adj[BCD_W-2:0], bin, 1'b0};
          carry      <= carry | bcd_adj[BCD_W-1];
          cnt        <= cnt - CNT_W'(1);
        end
        COMMIT: begin
          disp     <= bcd[4*DIGITS-1:0];
          disp_ovf <= carry | (bcd[BCD_W-1 -: 4] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div <= '0;
      idx <= (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_comb begin
    cur_nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 2'(i)) cur_nib = disp[4*i +: 4];
    end
  end

`ifdef SSD_LZB_EN
  logic [DIGITS-1:0] blank_mask;
  logic              lead;

  always_comb begin
    lead       = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead          = lead & (disp[4*i +: 4] == 4'd0);
      blank_mask[i] = lead;
    end
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 2'(i)) cur_blank = blank_mask[i];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      SSD <= 7'b1111111;
      AN  <= '1;
    end else begin
      AN <= ~(DIGITS'(1) << idx);
      if (disp_ovf)       SSD <= 7'b0111111;
      else if (cur_blank) SSD <= 7'b1111111;
      else                SSD <= seg_code(cur_nib);
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver, DIGITS=2 BIN_W=7 SCAN_DIV=4.
module tb_ssd_scan_driver;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;
`ifdef SSD_LZB_EN
  localparam logic [6:0] LZ   = OFF;
`else
  localparam logic [6:0] LZ   = S0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load, busy;
  logic [6:0] value, SSD;
  logic [1:0] AN;
  int         checks = 0;
  int         failures = 0;

  ssd_scan_driver #(.DIGITS(2), .BIN_W(7), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value),
    .busy(busy), .SSD(SSD), .AN(AN)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output bit ok);
    logic [1:0] prev;
    ok   = 1'b0;
    prev = AN;
    for (int i = 0; i < 24 && !ok; i++) begin
      tick();
      if (prev == 2'b01 && AN == 2'b10) ok = 1'b1;
      prev = AN;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic do_load(input logic [6:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0; value = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (SSD !== OFF || AN !== 2'b11 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d SSD=%b AN=%b busy=%b want %b 11 0",
                 i, SSD, AN, busy, OFF);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (AN !== ((i < 4) ? 2'b10 : 2'b01) ||
          SSD !== ((i < 4) ? S0 : LZ) || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_release cyc%0d SSD=%b AN=%b busy=%b", i, SSD, AN, busy);
      end
    end
  endtask

  task automatic test_convert();
    bit ok;
    do_load(7'd37);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (busy !== (i < 8)) begin
        failures++;
        $display("FAIL busy_len cyc%0d busy=%b want %b", i, busy, i < 8);
      end
      tick();
    end
    wait_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL conv37_align timeout"); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (AN !== ((i < 4) ? 2'b10 : 2'b01) || SSD !== ((i < 4) ? S7 : S3)) begin
        failures++;
        $display("FAIL conv37 cyc%0d AN=%b SSD=%b", i, AN, SSD);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [6:0] vals [3] = '{7'd100, 7'd127, 7'd99};
    for (int v = 0; v < 3; v++) begin
      do_load(vals[v]);
      wait_idle(ok);
      wait_frame(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL ovf_align v=%0d timeout", vals[v]); end
      for (int i = 0; i < 8; i++) begin
        if (i > 0) tick();
        checks++;
        if (AN !== ((i < 4) ? 2'b10 : 2'b01) ||
            SSD !== ((vals[v] >= 7'd100) ? DASH : S9)) begin
          failures++;
          $display("FAIL ovf v=%0d cyc%0d AN=%b SSD=%b", vals[v], i, AN, SSD);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    do_load(7'd9);
    tick();
    do_load(7'd58);
    wait_idle(ok);
    wait_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ignore_align timeout"); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (AN !== ((i < 4) ? 2'b10 : 2'b01) || SSD !== ((i < 4) ? S9 : LZ)) begin
        failures++;
        $display("FAIL ignore cyc%0d AN=%b SSD=%b", i, AN, SSD);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_load(7'd5);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_idle timeout"); end
    do_load(7'd58);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy=%b want 1", busy);
    end
    wait_idle(ok);
    wait_frame(ok);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (AN !== ((i < 4) ? 2'b10 : 2'b01) || SSD !== ((i < 4) ? S8 : S5)) begin
        failures++;
        $display("FAIL b2b58 cyc%0d AN=%b SSD=%b", i, AN, SSD);
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    wait_frame(ok);
    tick();
    en = 1'b0;
    tick();
    checks++;
    if (SSD !== OFF || AN !== 2'b11) begin
      failures++;
      $display("FAIL en_off SSD=%b AN=%b want %b 11", SSD, AN, OFF);
    end
    tick();
    tick();
    tick();
    checks++;
    if (SSD !== OFF || AN !== 2'b11) begin
      failures++;
      $display("FAIL en_off_hold SSD=%b AN=%b", SSD, AN);
    end
    en = 1'b1;
    tick();
    checks++;
    if (AN !== 2'b01 || SSD !== S5) begin
      failures++;
      $display("FAIL en_restore AN=%b SSD=%b want 01 %b", AN, SSD, S5);
    end
    tick();
    tick();
    checks++;
    if (AN !== 2'b10 || SSD !== S8) begin
      failures++;
      $display("FAIL en_continue AN=%b SSD=%b want 10 %b", AN, SSD, S8);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_load(7'd45);
    tick();
    tick();
    rst   = 1'b1;
    load  = 1'b1;
    value = 7'd45;
    tick();
    checks++;
    if (busy !== 1'b0 || SSD !== OFF || AN !== 2'b11) begin
      failures++;
      $display("FAIL rst_mid busy=%b SSD=%b AN=%b want 0 %b 11", busy, SSD, AN, OFF);
    end
    rst  = 1'b0;
    load = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle busy=%b want 0", busy);
    end
    wait_frame(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_mid_align timeout"); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (AN !== ((i < 4) ? 2'b10 : 2'b01) || SSD !== ((i < 4) ? S0 : LZ)) begin
        failures++;
        $display("FAIL rst_mid_disp cyc%0d AN=%b SSD=%b", i, AN, SSD);
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Multiplexed multi-digit seven-segment display driver for the traffic-light controller. It accepts a binary countdown value and converts it to BCD sequentially with shift-add-3 (double dabble). It then time-multiplexes the digits onto one shared segment bus with a one-hot anode scan. It replaces per-digit combinational decoders and adds overflow indication plus enable blanking.

## Interface
- DIGITS, 2, number of digits scanned (1..4)
- BIN_W, 7, width of binary input value (must satisfy 2^BIN_W - 1 < 10^4)
- SCAN_DIV, 50000, clk cycles each digit is held (>= 2)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- en  in  1  display enable; low blanks all segments and anodes
- load  in  1  one-cycle strobe requesting conversion of value
- value  in  BIN_W  unsigned binary number to display
- busy  out  1  high while a conversion is in progress
- SSD  out  7  segment drive, active-low, bit6=g … bit0=a (0 → 7'b1000000)
- AN  out  DIGITS  digit anodes, active-low one-hot; AN[0] = least significant digit

## Operation
- FSM states:
  - IDLE → CONV on load=1 (value captured into shift register, BCD accumulator cleared, bit counter = BIN_W).
  - CONV runs BIN_W cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left 1.
  - CONV → COMMIT when the bit counter reaches 0. COMMIT → IDLE unconditionally.
- The BCD accumulator is 4*DIGITS+4 bits wide; the extra nibble detects overflow.
- COMMIT writes the display register. If value ≥ 10^DIGITS (extra nibble ≠ 0 or the converted value exceeds the digits), every digit is set to the dash code 7'b0111111. Otherwise each digit gets its BCD nibble.
- load while busy (CONV or COMMIT) is ignored; no queuing.
- The display register holds its last committed contents until the next COMMIT.
- Scan:
  - A divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→…→DIGITS-1→0.
  - Scanning runs regardless of en and busy.
- Output stage (registered):
  - en=1: AN = ~(1<<index) and SSD = segment pattern of display digit[index].
  - en=0: AN = all ones and SSD = 7'b1111111.
- Segment codes 0-9 are the team's standard active-low set: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.

## Timing
- Reset values:
  - Outputs: SSD=7'b1111111, AN all ones, busy=0.
  - Internal: FSM=IDLE, display register all zeros, index=0, divider=0.
- Conversion latency:
  - load sampled at edge t.
  - busy=1 from t+1 through t+BIN_W+1.
  - Display register updated at edge t+BIN_W+1; busy=0 at t+BIN_W+2.
  - A new load is accepted at t+BIN_W+2.
- Output latency: one cycle from an index, en or display-register change to SSD/AN.
- Each digit is active for exactly SCAN_DIV cycles. The full frame is DIGITS*SCAN_DIV cycles.
- rst mid-conversion aborts it. The display register returns to zero and the old value is not retained.
- load and rst in the same cycle: rst wins.
- COMMIT and an index advance in the same cycle: both take effect; the new digit shows new data one cycle later.

## Configuration
- Macro SSD_LZB_EN (leading-zero blanking).
- Defined:
  - Most-significant zero digits are blanked: SSD=7'b1111111 while their anode is still driven.
  - Digit 0 is never blanked, so value 0 shows a single '0'.
  - Overflow dashes are never blanked.
- Undefined: all digits are always shown, including leading zeros (5 shows "05" for DIGITS=2).

## Test plan
- rst held 3 cycles, then released with en=1 → SSD=1000000 and AN=2'b10 on the first cycle after release. busy=0 throughout.
- DIGITS=2, BIN_W=7, SCAN_DIV=4; load value=37 → busy high for 8 cycles. After commit, AN=10 shows SSD=1111000 (7) and AN=01 shows SSD=0110000 (3), each for 4 cycles.
- value=100 with DIGITS=2 → both digits show 0111111 (dash).
- load value=9 and, during busy, a second load value=58 → the second load is ignored and the display shows "09", or " 9" (digit 1 blank) with SSD_LZB_EN.
- en dropped mid-frame → the next cycle gives SSD=1111111 and AN=11. When en is restored, the index continues from the free-running scan.
- rst asserted 3 cycles into a conversion of 45 → busy=0 next cycle and the display shows "00", or a single "0" with SSD_LZB_EN.
